// File: rtl/tick_period_monitor_pkg.sv
// Timebase definitions shared with the time-unit generators:
// width helper, tick/timeout derivation and monitor FSM encodings.
package tick_period_monitor_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_MEASURE = 2'd1;
  localparam state_t ST_LOST    = 2'd2;

  function automatic int Size(input int v);
    return $clog2(v + 1);
  endfunction

  function automatic int nb_tic(
    input int fclk,
    input int fwant
  );
    return fclk / fwant;
  endfunction

  function automatic int timeout_cycles(
    input int fclk,
    input int fwant,
    input int mult
  );
    return mult * nb_tic(fclk, fwant);
  endfunction

  function automatic int cpt_width(
    input int fclk,
    input int fwant,
    input int mult
  );
    return Size(timeout_cycles(fclk, fwant, mult));
  endfunction

endpackage

// File: rtl/tick_period_monitor_rise_detect.sv
// Registered rising-edge detector for the tick strobe; a long
// high pulse yields a single one-cycle event.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic pulse_in,
  output logic ev
);

  logic r_pulse_q;
  logic r_ev;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pulse_q <= 1'b0;
      r_ev      <= 1'b0;
    end else begin
      r_pulse_q <= pulse_in;
      r_ev      <= pulse_in & ~r_pulse_q;
    end
  end

  assign ev = r_ev;

endmodule

// File: rtl/tick_period_monitor.sv
// Tick period monitor: measures spacing of tick edges, flags
// off-tolerance periods and loss. Option: PERIOD_MINMAX_EN.
module tick_period_monitor
  import tick_period_monitor_pkg::*;
#(
  parameter int FREQ_CLK     = 50000000,
  parameter int FREQ_WANTED  = 20000,
  parameter int TOL          = 2,
  parameter int TIMEOUT_MULT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic pulse_in,
  output logic [cpt_width(FREQ_CLK, FREQ_WANTED, TIMEOUT_MULT)-1:0] period,
  output logic period_valid,
  output logic in_tol,
  output logic lost,
  output logic [7:0] err_count
`ifdef PERIOD_MINMAX_EN
  ,
  output logic [cpt_width(FREQ_CLK, FREQ_WANTED, TIMEOUT_MULT)-1:0] period_min,
  output logic [cpt_width(FREQ_CLK, FREQ_WANTED, TIMEOUT_MULT)-1:0] period_max
`endif
);

  localparam int NB_TIC   = nb_tic(FREQ_CLK, FREQ_WANTED);
  localparam int TIMEOUT  = timeout_cycles(FREQ_CLK, FREQ_WANTED, TIMEOUT_MULT);
  localparam int SIZE_CPT = Size(TIMEOUT);
  localparam int W_DIFF   = SIZE_CPT + 1;

  localparam logic [SIZE_CPT-1:0] C_LAST = SIZE_CPT'(TIMEOUT - 1);
  localparam logic [SIZE_CPT-1:0] C_ONE  = SIZE_CPT'(1);
  localparam logic signed [W_DIFF-1:0] C_NB  = W_DIFF'(NB_TIC);
  localparam logic signed [W_DIFF-1:0] C_TOL = W_DIFF'(TOL);

  logic                     w_ev;
  logic                     w_ok;
  logic signed [W_DIFF-1:0] w_diff;
  logic signed [W_DIFF-1:0] w_abs;

  state_t              r_state;
  logic [SIZE_CPT-1:0] r_cpt;
  logic [SIZE_CPT-1:0] r_period;
  logic                r_valid;
  logic                r_in_tol;
  logic                r_lost;
  logic [7:0]          r_err;
`ifdef PERIOD_MINMAX_EN
  logic [SIZE_CPT-1:0] r_min;
  logic [SIZE_CPT-1:0] r_max;
`endif

  rise_detect u_rise (
    .clk      (clk),
    .reset    (reset),
    .pulse_in (pulse_in),
    .ev       (w_ev)
  );

  // One extra bit keeps the signed difference from overflowing
  assign w_diff = $signed({1'b0, r_cpt}) - C_NB;
  assign w_abs  = w_diff[W_DIFF-1] ? -w_diff : w_diff;
  assign w_ok   = (w_abs <= C_TOL);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cpt    <= '0;
      r_period <= '0;
      r_valid  <= 1'b0;
      r_in_tol <= 1'b0;
      r_lost   <= 1'b0;
      r_err    <= '0;
`ifdef PERIOD_MINMAX_EN
      r_min    <= '1;
      r_max    <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      if (!enable) begin
        r_state <= ST_IDLE;
        r_cpt   <= '0;
        r_lost  <= 1'b0;
      end else begin
        unique case (r_state)
          ST_MEASURE: begin
            if (w_ev) begin
              r_period <= r_cpt;
              r_in_tol <= w_ok;
              r_valid  <= 1'b1;
              r_cpt    <= C_ONE;
              if (!w_ok && r_err != 8'hFF) r_err <= r_err + 8'd1;
`ifdef PERIOD_MINMAX_EN
              if (r_cpt < r_min) r_min <= r_cpt;
              if (r_cpt > r_max) r_max <= r_cpt;
`endif
            end else if (r_cpt == C_LAST) begin
              r_state <= ST_LOST;
              r_lost  <= 1'b1;
              r_cpt   <= '0;
            end else begin
              r_cpt <= r_cpt + C_ONE;
            end
          end
          // Spacing to the previous edge is unknown after a loss
          ST_LOST: begin
            if (w_ev) begin
              r_state <= ST_MEASURE;
              r_lost  <= 1'b0;
              r_cpt   <= C_ONE;
            end else begin
              r_cpt <= '0;
            end
          end
          default: begin
            if (w_ev) begin
              r_state <= ST_MEASURE;
              r_cpt   <= C_ONE;
            end else begin
              r_state <= ST_IDLE;
              r_cpt   <= '0;
            end
          end
        endcase
      end
    end
  end

  assign period       = r_period;
  assign period_valid = r_valid;
  assign in_tol       = r_in_tol;
  assign lost         = r_lost;
  assign err_count    = r_err;
`ifdef PERIOD_MINMAX_EN
  assign period_min   = r_min;
  assign period_max   = r_max;
`endif

endmodule
